instr_fetch_unit: RTL and testbench

- Front end of the RISC-V core: holds the PC, fetches 32-bit instructions from instruction memory over a valid/ready request plus response-valid interface, and presents the decoded fields to the control unit and datapath.
- Applies the control unit's PC select and the branch/jump target when the instruction is consumed.
- Supports an asynchronous-to-flow flush (trap/redirect) that discards an in-flight response.

---
 rtl/instr_fetch_unit_pkg.sv | 27 ++
 rtl/instr_fetch_unit_pc_reg.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit definitions: opcode map, NOP encoding, fetch FSM states.
package instr_fetch_unit_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic low_bits_set(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// PC register with next-PC selection: flush redirect, taken target or +4.
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            consume_i,
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;

  // Flush wins over a same-cycle consume; targets are forced word aligned.
  always_comb begin
    pc_d  = pc_q;
    mis_d = mis_q;
    if (flush_i) begin
      pc_d = {flush_pc_i[XLEN-1:2], 2'b00};
      if (low_bits_set(flush_pc_i[1:0])) begin
        mis_d = 1'b1;
      end
    end else if (consume_i) begin
      if (pc_sel_i) begin
        pc_d = {pc_target_i[XLEN-1:2], 2'b00};
        if (low_bits_set(pc_target_i[1:0])) begin
          mis_d = 1'b1;
        end
      end else begin
        pc_d = pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = mis_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: one outstanding imem request, holds the fetched
// instruction for decode, applies next-PC on consume and handles flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] pc_out,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] pc_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            misalign_err,
  output logic            instr_illegal,
  output logic [31:0]     fetch_count
);

  fetch_state_e    state_q, state_d;
  logic            kill_q, kill_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_out_q;
  logic [31:0]     count_q;
  logic [XLEN-1:0] pc;
  logic            latch;
  logic            consume;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .flush_pc_i  (flush_pc),
    .consume_i   (consume),
    .pc_sel_i    (pc_sel),
    .pc_target_i (pc_target),
    .pc_o        (pc),
    .misalign_o  (misalign_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    latch   = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = flush;
        end
      end
      S_WAIT: begin
        // A response meeting a pending or same-cycle flush is stale.
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || flush) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            latch   = 1'b1;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (instr_ready) begin
          state_d = S_REQ;
          consume = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    unique case (state_q)
      S_REQ:   imem_req_valid = 1'b1;
      S_HOLD:  instr_valid    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_q   <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      count_q  <= '0;
    end else begin
      kill_q <= kill_d;
      if (latch) begin
        instr_q  <= imem_rsp_data;
        pc_out_q <= pc;
      end
      if (consume) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_req_addr = pc;
  assign instr         = instr_q;
  assign opcode        = instr_q[6:0];
  assign rd            = instr_q[11:7];
  assign funct3        = instr_q[14:12];
  assign rs1           = instr_q[19:15];
  assign rs2           = instr_q[24:20];
  assign funct7        = instr_q[31:25];
  assign pc_out        = pc_out_q;
  assign instr_illegal = instr_q[1:0] != 2'b11;
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch, branch, flush,
// stall and reset scenarios against a small imem responder.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] pc_out;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        misalign_err;
  logic        instr_illegal;
  logic [31:0] fetch_count;

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .pc_out         (pc_out),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .misalign_err   (misalign_err),
    .instr_illegal  (instr_illegal),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  int          errors = 0;
  int          checks = 0;
  int          rsp_delay = 1;
  int          exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h000: return 32'h0050_0093; // addi x1,x0,5
      32'h004: return 32'h00A0_0113; // addi x2,x0,10
      32'h100: return 32'h0020_81B3; // add x3,x1,x2
      32'h104: return 32'hFFFF_FFFF;
      32'h200: return 32'h4020_8233; // sub x4,x1,x2
      32'h300: return 32'h1234_52B7; // lui x5,0x12345
      32'h304: return 32'h0000_4501;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // imem model: answers an accepted request rsp_delay cycles later
  initial begin : responder
    logic        acc;
    logic [31:0] acc_addr;
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 0;
    cnt = 0;
    paddr = 0;
    imem_rsp_valid = 0;
    imem_rsp_data = 0;
    forever begin
      @(negedge clk);
      acc = !rst && imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 0;
      if (acc) begin
        pend = 1;
        cnt = rsp_delay;
        paddr = acc_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_rsp_valid = 1;
          imem_rsp_data = mem(paddr);
          pend = 0;
        end
      end
    end
  end

  initial begin : monitor
    logic        prev_v;
    exp_t        e;
    logic [31:0] a;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got %h expected none", imem_req_addr);
        end else begin
          a = req_q.pop_front();
          chk("req_addr", imem_req_addr, a);
        end
      end
      if (!rst && instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL instr_unexpected: got %h expected none", instr);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr, e.ins);
          chk("pc_out", pc_out, e.pc);
          chk("opcode", 32'(opcode), 32'(e.ins[6:0]));
          chk("rd", 32'(rd), 32'(e.ins[11:7]));
          chk("funct3", 32'(funct3), 32'(e.ins[14:12]));
          chk("rs1", 32'(rs1), 32'(e.ins[19:15]));
          chk("rs2", 32'(rs2), 32'(e.ins[24:20]));
          chk("funct7", 32'(funct7), 32'(e.ins[31:25]));
        end
      end
      prev_v = instr_valid;
    end
  end

  task automatic wait_present(input int max);
    for (int i = 0; i < max; i++) begin
      if (instr_valid) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL present_timeout: got no instr_valid expected within %0d", max);
  endtask

  task automatic consume(input logic sel, input logic [31:0] tgt);
    instr_ready = 1;
    pc_sel = sel;
    pc_target = tgt;
    step();
    instr_ready = 0;
    pc_sel = 0;
    pc_target = 0;
    exp_cnt++;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_pc_out"}, pc_out, 32'd0);
    chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
    chk({tag, "_count"}, fetch_count, 32'd0);
    chk({tag, "_illegal"}, 32'(instr_illegal), 32'd0);
  endtask

  initial begin : stim
    rst = 1;
    imem_req_ready = 1;
    instr_ready = 0;
    pc_sel = 0;
    pc_target = 0;
    flush = 0;
    flush_pc = 0;
    step();
    step();
    chk_reset_outs("rst");

    req_q.push_back(32'h000);
    exp_q.push_back('{32'h0050_0093, 32'h000});
    rst = 0;
    step();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h000);
    wait_present(10);
    chk("first_opcode", 32'(opcode), 32'h13);
    chk("first_rd", 32'(rd), 32'd1);

    req_q.push_back(32'h004);
    exp_q.push_back('{32'h00A0_0113, 32'h004});
    consume(0, 0);
    chk("seq_addr", imem_req_addr, 32'h004);
    chk("count1", fetch_count, 32'(exp_cnt));

    wait_present(10);
    req_q.push_back(32'h100);
    exp_q.push_back('{32'h0020_81B3, 32'h100});
    consume(1, 32'h100);
    chk("br_addr", imem_req_addr, 32'h100);
    chk("count2", fetch_count, 32'(exp_cnt));
    chk("misalign_clear", 32'(misalign_err), 32'd0);

    wait_present(10);
    req_q.push_back(32'h100);
    exp_q.push_back('{32'h0020_81B3, 32'h100});
    consume(1, 32'h102);
    chk("mis_addr", imem_req_addr, 32'h100);
    chk("misalign_set", 32'(misalign_err), 32'd1);

    // flush while waiting: the 0x104 response must be dropped
    wait_present(10);
    rsp_delay = 3;
    req_q.push_back(32'h104);
    req_q.push_back(32'h200);
    exp_q.push_back('{32'h4020_8233, 32'h200});
    consume(0, 0);
    step();
    flush = 1;
    flush_pc = 32'h200;
    step();
    flush = 0;
    rsp_delay = 1;
    wait_present(20);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);
    chk("count_after_wait_flush", fetch_count, 32'(exp_cnt));

    // flush in HOLD overrides a simultaneous consume
    req_q.push_back(32'h300);
    exp_q.push_back('{32'h1234_52B7, 32'h300});
    instr_ready = 1;
    pc_sel = 1;
    pc_target = 32'h400;
    flush = 1;
    flush_pc = 32'h300;
    step();
    instr_ready = 0;
    pc_sel = 0;
    flush = 0;
    chk("hold_flush_valid", 32'(instr_valid), 32'd0);
    chk("hold_flush_count", fetch_count, 32'(exp_cnt));
    chk("hold_flush_addr", imem_req_addr, 32'h300);

    // imem stall: request must hold steady
    wait_present(10);
    req_q.push_back(32'h304);
    exp_q.push_back('{32'h0000_4501, 32'h304});
    imem_req_ready = 0;
    consume(0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_addr", imem_req_addr, 32'h304);
      step();
    end
    imem_req_ready = 1;
    wait_present(10);
    chk("illegal", 32'(instr_illegal), 32'd1);

    // reset in WAIT; the late response must be ignored
    rsp_delay = 4;
    req_q.push_back(32'h308);
    consume(0, 0);
    step();
    imem_req_ready = 0;
    rst = 1;
    #1;
    chk_reset_outs("midrst");
    step();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_ivalid", 32'(instr_valid), 32'd0);
      chk("post_rst_req", 32'(imem_req_valid), 32'd1);
      chk("post_rst_addr", imem_req_addr, 32'h000);
      chk("post_rst_instr", instr, 32'h0000_0013);
    end

    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
